// File: rtl/lifo_ext.sv
// lifo_ext: parametrised synchronous LIFO with non-power-of-two depth,
// simultaneous push+pop, almost flags, read-valid strobe, sticky errors.
//
// Ports:
//   clk_i          clock, all logic on rising edge
//   srst_n_i       synchronous reset, active-low, priority over requests
//   push_i/data_i  push request and data
//   pop_i          pop request
//   clr_err_i      clears sticky overflow/underflow flags (a new error wins)
//   q_o/q_valid_o  registered popped data and its one-cycle strobe
//   usedw_o        entry count 0..DEPTH
//   empty_o/full_o/almost_empty_o/almost_full_o   registered status flags
//   overflow_o/underflow_o   sticky error flags for dropped requests
module lifo_ext #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              q_valid_o,
    output logic [CW-1:0]     usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              is_empty;
    logic              is_full;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     wr_addr;
    logic              wr_en;
    logic              rd_en;
    logic              pass_en;
    logic              ovf_evt;
    logic              unf_evt;
    logic [CW-1:0]     usedw_nxt;

    assign is_empty = (usedw_o == '0);
    assign is_full  = (usedw_o == FULL_CNT);
    // Only meaningful when the stack is non-empty; the wrap at zero is unused.
    assign top_addr = AW'(usedw_o - CW'(1));

    // Request decode. The write pointer is the count itself, so a plain
    // push lands at usedw_o and a replace-top lands at usedw_o-1.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = AW'(usedw_o);
        rd_en     = 1'b0;
        pass_en   = 1'b0;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        usedw_nxt = usedw_o;
        unique case ({push_i, pop_i})
            2'b11: begin
                if (is_empty) begin
                    pass_en = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end
            end
            2'b10: begin
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    usedw_nxt = usedw_o + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    rd_en     = 1'b1;
                    usedw_nxt = usedw_o - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Storage is not reset; writes are suppressed in a reset cycle so the
    // request is ignored there as well.
    always_ff @(posedge clk_i) begin
        if (wr_en && srst_n_i) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Read data register. A replace-top reads the old word because the
    // memory write above is non-blocking (read-before-write).
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            q_o       <= '0;
            q_valid_o <= 1'b0;
        end else begin
            q_valid_o <= rd_en | pass_en;
            if (rd_en) begin
                q_o <= mem[top_addr];
            end else if (pass_en) begin
                q_o <= data_i;
            end
        end
    end

    // Count and status flags, all derived from the next-state count.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= (AE_THRESH >= 0);
            almost_full_o  <= (AF_THRESH <= 0);
        end else begin
            usedw_o        <= usedw_nxt;
            empty_o        <= (usedw_nxt == '0);
            full_o         <= (usedw_nxt == FULL_CNT);
            almost_empty_o <= (int'(usedw_nxt) <= AE_THRESH);
            almost_full_o  <= (int'(usedw_nxt) >= AF_THRESH);
        end
    end

    // Sticky errors: clear request loses against a same-cycle new error.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_evt | (overflow_o & ~clr_err_i);
            underflow_o <= unf_evt | (underflow_o & ~clr_err_i);
        end
    end

endmodule

// File: tb/tb_lifo_ext.sv
// Testbench for lifo_ext: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue model.
module tb_lifo_ext;

    localparam int DW = 8;
    localparam int DP = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          srst_n = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data = '0;
    logic          pop = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [CW-1:0] usedw;
    logic          empty, full, aempty, afull, ovf, unf;

    int checks = 0;
    int failures = 0;

    lifo_ext #(
        .DWIDTH(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk_i(clk), .srst_n_i(srst_n), .push_i(push), .data_i(data),
        .pop_i(pop), .clr_err_i(clr), .q_o(q), .q_valid_o(q_valid),
        .usedw_o(usedw), .empty_o(empty), .full_o(full),
        .almost_empty_o(aempty), .almost_full_o(afull),
        .overflow_o(ovf), .underflow_o(unf)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue whose back is the top of stack.
    logic [DW-1:0] stk [$];
    logic [DW-1:0] m_q = '0;
    bit            m_qv = 0;
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_ok = 0;

    always @(posedge clk) begin
        bit oe, ue;
        int n;
        oe = 0;
        ue = 0;
        if (!srst_n) begin
            stk.delete();
            m_q = '0;
            m_qv = 0;
            m_ovf = 0;
            m_unf = 0;
            m_ok = 1;
        end else begin
            n = stk.size();
            m_qv = 0;
            if (push && pop) begin
                m_qv = 1;
                if (n > 0) begin
                    m_q = stk[n-1];
                    stk[n-1] = data;
                end else begin
                    m_q = data;
                end
            end else if (push) begin
                if (n < DP) stk.push_back(data);
                else oe = 1;
            end else if (pop) begin
                if (n > 0) begin
                    m_q = stk.pop_back();
                    m_qv = 1;
                end else begin
                    ue = 1;
                end
            end
            m_ovf = oe || (m_ovf && !clr);
            m_unf = ue || (m_unf && !clr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int n;
        if (m_ok) begin
            n = stk.size();
            chk("m_usedw", int'(usedw), n);
            chk("m_empty", int'(empty), int'(n == 0));
            chk("m_full", int'(full), int'(n == DP));
            chk("m_aempty", int'(aempty), int'(n <= AE));
            chk("m_afull", int'(afull), int'(n >= AF));
            chk("m_qvalid", int'(q_valid), int'(m_qv));
            chk("m_q", int'(q), int'(m_q));
            chk("m_ovf", int'(ovf), int'(m_ovf));
            chk("m_unf", int'(unf), int'(m_unf));
        end
    end

    // Apply one cycle of inputs (called at a negedge) and wait until the
    // registered response is visible at the following negedge.
    task automatic cyc(input bit p, input logic [DW-1:0] d,
                       input bit po, input bit c, input bit r);
        push = p;
        data = d;
        pop = po;
        clr = c;
        srst_n = r;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 1);
    endtask

    task automatic do_rst();
        cyc(0, '0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        do_rst();
        do_rst();
        chk("rst_usedw", int'(usedw), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_aempty", int'(aempty), 1);
        chk("rst_afull", int'(afull), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_qv", int'(q_valid), 0);
        chk("rst_err", int'({ovf, unf}), 0);

        cyc(1, 8'h11, 0, 0, 1);
        cyc(1, 8'h22, 0, 0, 1);
        cyc(1, 8'h33, 0, 0, 1);
        chk("push3_usedw", int'(usedw), 3);
        chk("push3_empty", int'(empty), 0);
        cyc(0, '0, 1, 0, 1);
        chk("pop1_q", int'({q_valid, q}), 'h133);
        cyc(0, '0, 1, 0, 1);
        chk("pop2_q", int'({q_valid, q}), 'h122);
        cyc(0, '0, 1, 0, 1);
        chk("pop3_q", int'({q_valid, q}), 'h111);
        chk("pop3_empty", int'({usedw, empty}), 1);
        idle();
        chk("hold_q", int'({q_valid, q}), 'h011);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'hA0 + 8'(i), 0, 0, 1);
            if (i == 3) chk("af_4th", int'({afull, full}), 'b10);
        end
        chk("full5", int'({afull, full}), 'b11);
        cyc(1, 8'hFF, 0, 0, 1);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_usedw", int'(usedw), 5);
        cyc(0, '0, 1, 0, 1);
        chk("ovf_pop", int'(q), 'hA4);
        cyc(0, '0, 0, 1, 1);
        chk("ovf_clr", int'(ovf), 0);

        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 1);
        chk("drain_q", int'(q), 'hA0);
        cyc(0, '0, 1, 0, 1);
        chk("unf_flag", int'(unf), 1);
        chk("unf_q", int'({q_valid, q}), 'h0A0);
        cyc(0, '0, 0, 1, 1);
        chk("unf_clr", int'(unf), 0);
        cyc(0, '0, 1, 1, 1);
        chk("unf_setwins", int'(unf), 1);
        cyc(0, '0, 0, 1, 1);

        cyc(1, 8'h01, 0, 0, 1);
        cyc(1, 8'h02, 0, 0, 1);
        cyc(1, 8'h77, 1, 0, 1);
        chk("rt_q", int'({q_valid, q}), 'h102);
        chk("rt_usedw", int'(usedw), 2);
        cyc(0, '0, 1, 0, 1);
        chk("rt_next", int'(q), 'h77);
        for (int i = 0; i < 4; i++) cyc(1, 8'hB0 + 8'(i), 0, 0, 1);
        cyc(1, 8'hC5, 1, 0, 1);
        chk("rtf_q", int'({q_valid, q}), 'h1B3);
        chk("rtf_full", int'({full, ovf}), 'b10);
        cyc(0, '0, 1, 0, 1);
        chk("rtf_next", int'(q), 'hC5);

        do_rst();
        cyc(1, 8'h5A, 1, 0, 1);
        chk("pt_q", int'({q_valid, q}), 'h15A);
        chk("pt_state", int'({usedw, empty, ovf, unf}), 'b000_1_0_0);

        cyc(1, 8'h61, 0, 0, 1);
        cyc(1, 8'h62, 0, 0, 1);
        cyc(1, 8'h63, 0, 0, 1);
        cyc(1, 8'h64, 0, 0, 0);
        chk("mrst_usedw", int'({usedw, empty, full}), 'b000_1_0);
        chk("mrst_q", int'({q_valid, q}), 0);
        cyc(0, '0, 1, 0, 1);
        chk("mrst_unf", int'({unf, q_valid}), 'b10);

        for (int i = 0; i < 3000; i++) begin
            bit p, po, c, r;
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(99) < bias);
            po = ($urandom_range(99) < (100 - bias));
            c = ($urandom_range(99) < 6);
            r = ($urandom_range(999) >= 8);
            cyc(p, DW'($urandom), po, c, r);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_ext.md
Name: lifo_ext

Overview:
Parametrised synchronous LIFO (stack), the successor to the team's basic LIFO. Adds arbitrary (non-power-of-two) depth, legal simultaneous push+pop, programmable almost-full/almost-empty flags, and a read-valid strobe. Illegal requests are guarded: they are dropped and latched into sticky error flags instead of corrupting state. Used as scratch/return-stack storage in datapath blocks; single clock domain.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
AF_THRESH, DEPTH-2, almost_full_o asserted when usedw_o >= AF_THRESH
AE_THRESH, 1, almost_empty_o asserted when usedw_o <= AE_THRESH
CW (localparam), $clog2(DEPTH+1), usedw_o width

Ports:
clk_i  in  1  clock, all logic on rising edge
srst_n_i  in  1  synchronous reset, active-low
push_i  in  1  push request
data_i  in  DWIDTH  push data
pop_i  in  1  pop request
clr_err_i  in  1  clears sticky error flags
q_o  out  DWIDTH  popped data, registered
q_valid_o  out  1  one-cycle strobe, q_o updated this cycle
usedw_o  out  CW  current entry count, 0..DEPTH
empty_o  out  1  usedw_o == 0
full_o  out  1  usedw_o == DEPTH
almost_empty_o  out  1  usedw_o <= AE_THRESH
almost_full_o  out  1  usedw_o >= AF_THRESH
overflow_o  out  1  sticky: push dropped while full
underflow_o  out  1  sticky: pop dropped while empty

Behaviour:
- One clock; reset is synchronous and active-low (srst_n_i sampled on rising clk_i; clk_i/srst_n_i named per codebase convention).
- Reset values: usedw_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0), q_o=0, q_valid_o=0, overflow_o=0, underflow_o=0. Memory contents not reset.
- Reset has priority over all requests; reset mid-operation discards all stored data logically (usedw_o=0), requests in a reset cycle are ignored.
- Storage: mem[0..DEPTH-1], top of stack = mem[usedw_o-1]. Write pointer is usedw_o itself; no wrap-around (depth is not power of two).
- All flags registered, derived from next-state usedw; valid the cycle after the request.
- Cases per cycle (N = usedw_o), response registered at next edge:
  push only, N<DEPTH: mem[N]<=data_i, N+1.
  push only, N==DEPTH: dropped, overflow_o<=1, state unchanged.
  pop only, N>0: q_o<=mem[N-1], q_valid_o<=1, N-1.
  pop only, N==0: dropped, underflow_o<=1, q_valid_o<=0, q_o holds.
  push+pop, N>0 (incl. full): replace-top: q_o<=old mem[N-1] (read-before-write), mem[N-1]<=data_i, q_valid_o<=1, N unchanged; no error.
  push+pop, N==0: pass-through: q_o<=data_i, q_valid_o<=1, nothing stored, N stays 0; no error.
- Pop latency 1 cycle; q_o holds last popped value when no pop; q_valid_o high exactly one cycle per accepted pop.
- clr_err_i clears both sticky flags next cycle; if a new error occurs in the same cycle, the flag stays set (set wins).
- Synthesis: memory inferable as simple dual-port sync RAM with read-before-write on same address.

Test Plan:
DWIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1. After reset: push 0x11,0x22,0x33 -> usedw_o=3, empty_o=0; pop x3 -> q_o 0x33,0x22,0x11 each 1 cycle after pop with q_valid_o=1, then usedw_o=0, empty_o=1.
Push 5 words 0xA0..0xA4 -> full_o=1, almost_full_o=1 after 4th push; 6th push 0xFF -> overflow_o=1, usedw_o=5; pop returns 0xA4 (0xFF not stored).
Empty stack, pop -> underflow_o=1, q_valid_o=0, q_o unchanged; clr_err_i pulse -> underflow_o=0 next cycle; pop + clr_err_i same cycle while empty -> underflow_o stays 1.
Stack holding 0x01,0x02 (top 0x02); push 0x77 + pop same cycle -> q_o=0x02, q_valid_o=1, usedw_o=2; next pop -> 0x77. Repeat on full stack -> full_o stays 1, no overflow.
Empty stack, push 0x5A + pop same cycle -> q_o=0x5A, q_valid_o=1, usedw_o=0, empty_o=1, no error flags.
Push 3 words, assert srst_n_i=0 one cycle with push_i=1 -> usedw_o=0, all outputs at reset values; subsequent pop -> underflow_o=1.
